// File: rtl/l2_pmem_adaptor_pkg.sv
// Shared cache constants and the adaptor state encoding.
package l2_pmem_adaptor_pkg;

    localparam int          BEAT_W     = 64;
    localparam int          BEATS      = 4;
    localparam int          LINE_W     = 256;
    // Clears the byte-within-line offset of a 256-bit (32-byte) line address.
    localparam logic [31:0] LINE_ALIGN = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/l2_pmem_adaptor_if.sv
// L2-side line port and memory-side beat port of the adaptor.
interface l2_pmem_adaptor_if
    import l2_pmem_adaptor_pkg::*;
#(
    parameter int BEAT_W = l2_pmem_adaptor_pkg::BEAT_W
);
    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata256;
    logic [LINE_W-1:0] mem_rdata256;
    logic              mem_resp;

    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Environment view: issues L2 requests and plays the memory.
    modport master (
        output mem_address, mem_read, mem_write, mem_wdata256,
        input  mem_rdata256, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    // Adaptor view.
    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata256,
        output mem_rdata256, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l2_pmem_adaptor.sv
// Converts 256-bit L2 line fills/writebacks into BEATS-beat memory bursts.
module l2_pmem_adaptor
    import l2_pmem_adaptor_pkg::*;
#(
    parameter int BEAT_W = l2_pmem_adaptor_pkg::BEAT_W,
    parameter int BEATS  = l2_pmem_adaptor_pkg::BEATS
) (
    input  logic              clk,
    input  logic              rst,
    l2_pmem_adaptor_if.slave  bus
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rline_q, rline_d;
    logic              last_beat;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // State, beat counter, latched address and both line buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // Next-state: accept a request in IDLE (write wins), step beats on pmem_resp.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_write) begin
                    addr_d  = bus.mem_address & LINE_ALIGN;
                    wline_d = bus.mem_wdata256;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (bus.mem_read) begin
                    addr_d  = bus.mem_address & LINE_ALIGN;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (bus.pmem_resp) begin
                    rline_d[cnt_q*BEAT_W +: BEAT_W] = bus.pmem_rdata;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WR_BURST: begin
                if (bus.pmem_resp) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pmem_read    = (state_q == RD_BURST);
    assign bus.pmem_write   = (state_q == WR_BURST);
    assign bus.mem_resp     = (state_q == DONE);
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wline_q[cnt_q*BEAT_W +: BEAT_W];
    assign bus.mem_rdata256 = rline_q;

endmodule

// File: tb/tb_l2_pmem_adaptor.sv
// Randomized bench for l2_pmem_adaptor with a line-level reference model.
module tb_l2_pmem_adaptor;
    localparam int BW = 64;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_pmem_adaptor_if #(.BEAT_W(BW)) ifc();

    l2_pmem_adaptor #(.BEAT_W(BW), .BEATS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: the fill line as memory has delivered it so far.
    logic [255:0] exp_rline;
    logic [63:0]  fixbeat [NB];
    bit           use_fix;
    bit           gap_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Issue one request at a negedge with the DUT idle; play memory until done.
    // mode: 0 back-to-back strobes, 1 random stalls, 2 fixed gap pattern.
    // abort_after >= 0 resets the DUT after that many read beats.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [255:0] wline, input int mode, input int abort_after);
        int          k;
        int          cyc;
        int          pidx;
        bit          resp;
        bit          rd_path;
        logic [63:0] beat;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:5], 5'b0};
        rd_path  = !wr;
        ifc.mem_address  = addr;
        ifc.mem_read     = rd;
        ifc.mem_write    = wr;
        ifc.mem_wdata256 = wline;
        ifc.pmem_resp    = 1'($urandom);
        ifc.pmem_rdata   = {$urandom, $urandom};
        @(negedge clk);
        k = 0; cyc = 0; pidx = 0;
        while (k < NB && cyc < 200) begin
            chk("pmem_read", ifc.pmem_read, rd_path);
            chk("pmem_write", ifc.pmem_write, wr);
            chk("pmem_address", ifc.pmem_address, exp_addr);
            chk("mem_resp_early", ifc.mem_resp, 0);
            chk("rdata_hold", ifc.mem_rdata256, exp_rline);
            if (wr) chk("pmem_wdata", ifc.pmem_wdata, wline[k*64 +: 64]);
            if (abort_after >= 0 && k == abort_after) begin
                rst = 1'b1;
                ifc.pmem_resp = 1'b0;
                ifc.mem_read  = 1'b0;
                ifc.mem_write = 1'b0;
                @(negedge clk);
                exp_rline = '0;
                chk("rst_mem_resp", ifc.mem_resp, 0);
                chk("rst_pmem_read", ifc.pmem_read, 0);
                chk("rst_pmem_write", ifc.pmem_write, 0);
                chk("rst_pmem_address", ifc.pmem_address, 0);
                chk("rst_pmem_wdata", ifc.pmem_wdata, 0);
                chk("rst_rdata", ifc.mem_rdata256, 0);
                rst = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    ifc.pmem_resp  = 1'b1;
                    ifc.pmem_rdata = {$urandom, $urandom};
                    @(negedge clk);
                    chk("stray_mem_resp", ifc.mem_resp, 0);
                    chk("stray_pmem_read", ifc.pmem_read, 0);
                    chk("stray_rdata", ifc.mem_rdata256, 0);
                end
                ifc.pmem_resp = 1'b0;
                return;
            end
            case (mode)
                0:       resp = 1'b1;
                1:       resp = ($urandom_range(0, 2) != 0);
                default: resp = gap_pat[pidx % 7];
            endcase
            pidx++;
            beat = use_fix ? fixbeat[k] : {$urandom, $urandom};
            ifc.pmem_resp    = resp;
            ifc.pmem_rdata   = beat;
            ifc.mem_address  = $urandom;
            ifc.mem_wdata256 = rnd_line();
            if (resp) begin
                if (rd_path) exp_rline[k*64 +: 64] = beat;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("beats_done", k, NB);
        chk("mem_resp", ifc.mem_resp, 1);
        chk("done_pmem_read", ifc.pmem_read, 0);
        chk("done_pmem_write", ifc.pmem_write, 0);
        chk("done_rdata", ifc.mem_rdata256, exp_rline);
        ifc.mem_read   = 1'b0;
        ifc.mem_write  = 1'b0;
        ifc.pmem_resp  = 1'($urandom);
        ifc.pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("idle_mem_resp", ifc.mem_resp, 0);
        chk("idle_pmem_read", ifc.pmem_read, 0);
        chk("idle_pmem_write", ifc.pmem_write, 0);
    endtask

    initial begin
        logic [255:0] wl;
        logic [255:0] fill_exp;
        rst = 1'b1;
        use_fix = 1'b0;
        exp_rline = '0;
        ifc.mem_address  = '0;
        ifc.mem_read     = 1'b0;
        ifc.mem_write    = 1'b0;
        ifc.mem_wdata256 = '0;
        ifc.pmem_rdata   = '0;
        ifc.pmem_resp    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mem_resp", ifc.mem_resp, 0);
        chk("reset_pmem_read", ifc.pmem_read, 0);
        chk("reset_pmem_write", ifc.pmem_write, 0);
        chk("reset_pmem_address", ifc.pmem_address, 0);
        chk("reset_pmem_wdata", ifc.pmem_wdata, 0);
        chk("reset_rdata", ifc.mem_rdata256, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed fill, back-to-back strobes.
        fixbeat[0] = 64'h1111_1111_1111_1111;
        fixbeat[1] = 64'h2222_2222_2222_2222;
        fixbeat[2] = 64'h3333_3333_3333_3333;
        fixbeat[3] = 64'h4444_4444_4444_4444;
        use_fix = 1'b1;
        run_txn(1'b0, 1'b1, 32'h0000_1234, '0, 0, -1);
        use_fix = 1'b0;
        fill_exp = {fixbeat[3], fixbeat[2], fixbeat[1], fixbeat[0]};
        chk("directed_fill_line", ifc.mem_rdata256, fill_exp);

        // Directed writeback.
        wl = {{8{16'hAAAA}}, {8{16'hBBBB}}};
        run_txn(1'b1, 1'b0, 32'h8000_00FF, wl, 0, -1);
        chk("rdata_after_write", ifc.mem_rdata256, fill_exp);

        // Fill with the gap pattern.
        run_txn(1'b0, 1'b1, $urandom, '0, 2, -1);

        // Read and write together: write wins.
        run_txn(1'b1, 1'b1, $urandom, rnd_line(), 1, -1);

        // Reset after two beats of a fill, then a clean fill.
        run_txn(1'b0, 1'b1, $urandom, '0, 0, 2);
        run_txn(1'b0, 1'b1, $urandom, '0, 0, -1);

        // Writeback immediately followed by fill.
        run_txn(1'b1, 1'b0, $urandom, rnd_line(), 0, -1);
        run_txn(1'b0, 1'b1, $urandom, '0, 0, -1);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            bit w;
            bit r;
            w = 1'($urandom);
            r = w ? 1'($urandom) : 1'b1;
            run_txn(w, r, $urandom, rnd_line(), $urandom_range(0, 2), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/l2_pmem_adaptor.md
L2_PMEM_ADAPTOR -- requirements
Module: l2_pmem_adaptor

Interface
REQ-001 SHALL have parameter BEAT_W, default 64, meaning width of one memory-bus beat.
REQ-002 SHALL have parameter BEATS, default 4, meaning beats per 256-bit line; BEAT_W*BEATS SHALL equal 256.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_address  input  32  L2-side line address.
REQ-006 mem_read  input  1  L2 line-fill request, held until mem_resp.
REQ-007 mem_write  input  1  L2 writeback request, held until mem_resp.
REQ-008 mem_wdata256  input  256  writeback line from the L2 datapath.
REQ-009 mem_rdata256  output  256  assembled fill line to the L2 datapath.
REQ-010 mem_resp  output  1  one-cycle transaction-complete pulse.
REQ-011 pmem_address  output  32  line-aligned memory address.
REQ-012 pmem_read / pmem_write  output  1 each  memory burst requests.
REQ-013 pmem_wdata  output  BEAT_W  current write beat.
REQ-014 pmem_rdata  input  BEAT_W  current read beat.
REQ-015 pmem_resp  input  1  beat-accept/beat-valid strobe from memory.

Function
REQ-016 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE.
REQ-017 In IDLE with mem_write=1: latch mem_wdata256 and {mem_address[31:5],5'b0}, clear beat counter, go WR_BURST; write SHALL take priority when mem_read and mem_write are both high.
REQ-018 In IDLE with mem_read=1 and mem_write=0: latch the aligned address, clear beat counter, go RD_BURST.
REQ-019 pmem_read SHALL be 1 exactly while in RD_BURST; pmem_write exactly while in WR_BURST; both registered-state decodes, first asserted the cycle after acceptance.
REQ-020 pmem_address SHALL hold the latched aligned address, stable for the whole burst.
REQ-021 In RD_BURST, each cycle with pmem_resp=1 SHALL store pmem_rdata into line bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k], k = beat counter, and increment k.
REQ-022 In WR_BURST, pmem_wdata SHALL equal latched line beat k; each cycle with pmem_resp=1 increments k.
REQ-023 Cycles with pmem_resp=0 inside a burst SHALL be stalls: no state, counter, or data change.
REQ-024 On the beat with k=BEATS-1 and pmem_resp=1: go DONE; counter wraps to 0.
REQ-025 In DONE: mem_resp=1 for exactly that one cycle, then IDLE unconditionally; request inputs SHALL be ignored in DONE.
REQ-026 Minimum latency, request-high to mem_resp: 1 + BEATS + 1 = 6 cycles with back-to-back pmem_resp.
REQ-027 mem_rdata256 SHALL hold the last completed fill line until the next fill's first beat is written; a write transaction SHALL NOT alter it.
REQ-028 pmem_resp in IDLE or DONE SHALL be ignored.
REQ-029 Request inputs changing mid-burst SHALL be ignored; the latched transaction completes.

Reset
REQ-030 rst=1 SHALL force IDLE, counter 0, and within one edge: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_rdata256=0.
REQ-031 Reset mid-burst SHALL abort without mem_resp; any following pmem_resp SHALL be ignored.

Structure
REQ-032 State enum, BEAT_W, BEATS, and line width SHALL live in the shared cache package.
REQ-033 Single module, no sub-modules; beat indexing by part-select on the counter.

Verification
REQ-034 Read 0x0000_1234, pmem_resp high 4 cycles with beats 0x11..,0x22..,0x33..,0x44.. -> pmem_address=0x0000_1220, mem_rdata256={0x44..,0x33..,0x22..,0x11..}, mem_resp pulse on cycle 6.
REQ-035 Write line 0xAAAA..._BBBB... at 0x8000_00FF -> pmem_address=0x8000_00E0, pmem_wdata low beat first, four beats, mem_resp once.
REQ-036 Read with pmem_resp gaps (1,0,0,1,1,0,1) -> data correct, mem_resp exactly once after 4th strobe.
REQ-037 mem_read and mem_write high together -> WR_BURST taken, pmem_read never asserted.
REQ-038 rst after 2 beats of a read, then 2 stray pmem_resp -> no mem_resp, outputs at reset values, next read completes correctly.
REQ-039 Writeback immediately followed by fill -> second request accepted in IDLE after DONE, mem_rdata256 unchanged by the write.
